pixel_dispatcher: RTL and testbench

//  Drives (curr_x, curr_y) into the raymarcher and consumes its pixel_done/RGB result stream.

---
 rtl/raymarch_pkg.sv | 29 ++
 rtl/pixel_dispatcher_if.sv | 33 +++
 rtl/pixel_dispatcher_coord_counter.sv | 71 +++++++
 rtl/pixel_dispatcher.sv | 139 +++++++++++++
 tb/tb_pixel_dispatcher.sv | 386 ++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/raymarch_pkg.sv
// Shared types, framebuffer word width and pixel packing for the raymarch datapath.
// Build option FB_RGB565_EN: when defined the framebuffer word is 16-bit RGB565,
// otherwise it is 24-bit RGB888.
package raymarch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SYNC = 2'd1,
        RUN  = 2'd2
    } dispatcher_state_t;

`ifdef FB_RGB565_EN
    localparam int FB_W = 16;
`else
    localparam int FB_W = 24;
`endif

    // Packs one raymarcher colour into a framebuffer word.
    function automatic logic [FB_W-1:0] fb_pack(input logic [7:0] r,
                                                 input logic [7:0] g,
                                                 input logic [7:0] b);
`ifdef FB_RGB565_EN
        fb_pack = {r[7:3], g[7:2], b[7:3]};
`else
        fb_pack = {r, g, b};
`endif
    endfunction

endpackage

// File: rtl/pixel_dispatcher_if.sv
// Pixel stream bundle between raymarcher, dispatcher and framebuffer write port.
// master = dispatcher side, slave = raymarcher / framebuffer side.
interface pixel_dispatcher_if #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720
);
    import raymarch_pkg::*;

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    logic          pixel_done;
    logic [7:0]    red_in;
    logic [7:0]    green_in;
    logic [7:0]    blue_in;
    logic [XW-1:0] curr_x;
    logic [YW-1:0] curr_y;
    logic          fb_we;
    logic [AW-1:0] fb_addr;
    logic [FB_W-1:0] fb_data;

    modport master (
        input  pixel_done, red_in, green_in, blue_in,
        output curr_x, curr_y, fb_we, fb_addr, fb_data
    );

    modport slave (
        output pixel_done, red_in, green_in, blue_in,
        input  curr_x, curr_y, fb_we, fb_addr, fb_data
    );

endinterface

// File: rtl/pixel_dispatcher_coord_counter.sv
// Raster coordinate counter: x, y and linear address kept in step, so the
// address never needs a multiplier. lastO flags the final pixel of the frame.
module pixel_coord_counter #(
    parameter int WIDTH  = 1280,
    parameter int HEIGHT = 720,
    localparam int XW = $clog2(WIDTH),
    localparam int YW = $clog2(HEIGHT),
    localparam int AW = $clog2(WIDTH * HEIGHT)
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          clear_i,
    input  logic          advance_i,
    output logic [XW-1:0] x_o,
    output logic [YW-1:0] y_o,
    output logic [AW-1:0] addr_o,
    output logic          last_o
);

    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    logic [XW-1:0] x_q, x_d;
    logic [YW-1:0] y_q, y_d;
    logic [AW-1:0] addr_q, addr_d;

    // Next coordinate: clear wins over advance; raster order with wrap at frame end.
    always_comb begin
        x_d    = x_q;
        y_d    = y_q;
        addr_d = addr_q;
        if (clear_i) begin
            x_d    = '0;
            y_d    = '0;
            addr_d = '0;
        end else if (advance_i) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                if (y_q == Y_LAST) begin
                    y_d    = '0;
                    addr_d = '0;
                end else begin
                    y_d    = y_q + 1'b1;
                    addr_d = addr_q + 1'b1;
                end
            end else begin
                x_d    = x_q + 1'b1;
                addr_d = addr_q + 1'b1;
            end
        end
    end

    // Coordinate registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            x_q    <= '0;
            y_q    <= '0;
            addr_q <= '0;
        end else begin
            x_q    <= x_d;
            y_q    <= y_d;
            addr_q <= addr_d;
        end
    end

    assign x_o    = x_q;
    assign y_o    = y_q;
    assign addr_o = addr_q;
    assign last_o = (x_q == X_LAST) && (y_q == Y_LAST);

endmodule

// File: rtl/pixel_dispatcher.sv
// Pixel dispatcher: presents coordinates to the raymarcher and turns its
// pixel_done/RGB stream into framebuffer writes. The raymarcher answers one
// pixel late, so the coordinate owning each colour is held in pend*.
// Build option FB_RGB565_EN selects the framebuffer word packing (see raymarch_pkg).
module pixel_dispatcher
    import raymarch_pkg::*;
#(
    parameter int WIDTH      = 1280,
    parameter int HEIGHT     = 720,
    parameter int CONTINUOUS = 0
) (
    input  logic               clk_pixel_in,
    input  logic               rst_n_in,
    input  logic               start_in,
    pixel_dispatcher_if.master bus,
    output logic               busy,
    output logic               frame_done
);

    localparam int XW = $clog2(WIDTH);
    localparam int YW = $clog2(HEIGHT);
    localparam int AW = $clog2(WIDTH * HEIGHT);

    dispatcher_state_t state_q, state_d;

    logic [XW-1:0]   currX;
    logic [YW-1:0]   currY;
    logic [AW-1:0]   currAddr;
    logic            currLast;
    logic            currClear;
    logic            currAdvance;
    logic            pendLoad;
    logic            writeEn;
    logic            frameEnd;

    logic [AW-1:0]   pendAddr_q;
    logic            pendLast_q;
    logic            fbWe_q;
    logic [AW-1:0]   fbAddr_q;
    logic [FB_W-1:0] fbData_q;
    logic            frameDone_q;

    assign frameEnd = bus.pixel_done && pendLast_q;

    pixel_coord_counter #(
        .WIDTH (WIDTH),
        .HEIGHT(HEIGHT)
    ) u_curr (
        .clk_i    (clk_pixel_in),
        .rst_n_i  (rst_n_in),
        .clear_i  (currClear),
        .advance_i(currAdvance),
        .x_o      (currX),
        .y_o      (currY),
        .addr_o   (currAddr),
        .last_o   (currLast)
    );

    // State register.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: SYNC eats the first result, RUN ends the frame unless continuous.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_in) state_d = SYNC;
            SYNC:    if (bus.pixel_done) state_d = RUN;
            RUN:     if (frameEnd && (CONTINUOUS == 0)) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Per-state controls for the coordinate counter, pend copy and write strobe.
    always_comb begin
        currClear   = 1'b0;
        currAdvance = 1'b0;
        pendLoad    = 1'b0;
        writeEn     = 1'b0;
        busy        = 1'b0;
        case (state_q)
            IDLE: begin
                currClear = 1'b1;
            end
            SYNC: begin
                busy        = 1'b1;
                pendLoad    = bus.pixel_done;
                currAdvance = bus.pixel_done;
            end
            RUN: begin
                busy     = 1'b1;
                pendLoad = bus.pixel_done;
                writeEn  = bus.pixel_done;
                if (frameEnd && (CONTINUOUS == 0)) begin
                    currClear = 1'b1;
                end else begin
                    currAdvance = bus.pixel_done;
                end
            end
            default: ;
        endcase
    end

    // Pending coordinate and registered framebuffer write port.
    always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            pendAddr_q  <= '0;
            pendLast_q  <= 1'b0;
            fbWe_q      <= 1'b0;
            fbAddr_q    <= '0;
            fbData_q    <= '0;
            frameDone_q <= 1'b0;
        end else begin
            fbWe_q      <= writeEn;
            frameDone_q <= writeEn && pendLast_q;
            if (writeEn) begin
                fbAddr_q <= pendAddr_q;
                fbData_q <= fb_pack(bus.red_in, bus.green_in, bus.blue_in);
            end
            if (pendLoad) begin
                pendAddr_q <= currAddr;
                pendLast_q <= currLast;
            end
        end
    end

    assign bus.curr_x  = currX;
    assign bus.curr_y  = currY;
    assign bus.fb_we   = fbWe_q;
    assign bus.fb_addr = fbAddr_q;
    assign bus.fb_data = fbData_q;
    assign frame_done  = frameDone_q;

endmodule

// File: tb/tb_pixel_dispatcher.sv
// Bench for pixel_dispatcher on a 4x2 frame: dut0 single-frame, dut1 continuous.
// A behavioural raymarcher per DUT returns {x, y, 0x5A} two pulses after sampling.
module tb_pixel_dispatcher;
    import raymarch_pkg::*;

    localparam int W    = 4;
    localparam int H    = 2;
    localparam int NPIX = W * H;

`ifdef FB_RGB565_EN
    localparam logic [FB_W-1:0] LIT_PIX5 = 16'h000B;
    localparam logic [FB_W-1:0] LIT_PIX7 = 16'h000B;
    localparam logic [FB_W-1:0] LIT_OVR  = 16'hFC00;
`else
    localparam logic [FB_W-1:0] LIT_PIX5 = 24'h01015A;
    localparam logic [FB_W-1:0] LIT_PIX7 = 24'h03015A;
    localparam logic [FB_W-1:0] LIT_OVR  = 24'hFF8007;
`endif

    logic clk;
    logic rst_n;
    logic start [2];
    logic pdone [2];
    logic [7:0] red [2];
    logic [7:0] green [2];
    logic [7:0] blue [2];
    logic busy0, busy1, fd0, fd1;
    logic busyS [2];
    logic fdS [2];
    logic weS [2];
    logic [1:0] cxS [2];
    logic [0:0] cyS [2];
    logic [2:0] addrS [2];
    logic [FB_W-1:0] dataS [2];

    int checks = 0;
    int errors = 0;

    // raymarcher model state
    bit rmEn [2];
    int rmPeriod [2];
    int rmCnt [2];
    bit justPulsed [2];
    int s1x [2], s1y [2], s2x [2], s2y [2];
    int ovX = -1, ovY = -1, ovAddr = -1;

    // scoreboard state
    int expAddr [2];
    logic [FB_W-1:0] lastData [2];
    logic [FB_W-1:0] captured [2][NPIX];
    int writes [2];
    int frames [2];
    int runLen [2];
    int maxRun [2];
    bit sawDone [2];
    int pulseCount [2];
    int pulseAtFd [2];
    int lastFramePulses [2];

    pixel_dispatcher_if #(.WIDTH(W), .HEIGHT(H)) ifc0 ();
    pixel_dispatcher_if #(.WIDTH(W), .HEIGHT(H)) ifc1 ();

    pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .CONTINUOUS(0)) dut0 (
        .clk_pixel_in(clk),
        .rst_n_in    (rst_n),
        .start_in    (start[0]),
        .bus         (ifc0),
        .busy        (busy0),
        .frame_done  (fd0)
    );

    pixel_dispatcher #(.WIDTH(W), .HEIGHT(H), .CONTINUOUS(1)) dut1 (
        .clk_pixel_in(clk),
        .rst_n_in    (rst_n),
        .start_in    (start[1]),
        .bus         (ifc1),
        .busy        (busy1),
        .frame_done  (fd1)
    );

    assign ifc0.pixel_done = pdone[0];
    assign ifc0.red_in     = red[0];
    assign ifc0.green_in   = green[0];
    assign ifc0.blue_in    = blue[0];
    assign ifc1.pixel_done = pdone[1];
    assign ifc1.red_in     = red[1];
    assign ifc1.green_in   = green[1];
    assign ifc1.blue_in    = blue[1];

    assign busyS[0] = busy0;
    assign busyS[1] = busy1;
    assign fdS[0]   = fd0;
    assign fdS[1]   = fd1;
    assign weS[0]   = ifc0.fb_we;
    assign weS[1]   = ifc1.fb_we;
    assign cxS[0]   = ifc0.curr_x;
    assign cxS[1]   = ifc1.curr_x;
    assign cyS[0]   = ifc0.curr_y;
    assign cyS[1]   = ifc1.curr_y;
    assign addrS[0] = ifc0.fb_addr;
    assign addrS[1] = ifc1.fb_addr;
    assign dataS[0] = ifc0.fb_data;
    assign dataS[1] = ifc1.fb_data;

    // Free-running pixel clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard stop in case a bounded wait is ever miscounted.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string name, input longint unsigned actual,
                               input longint unsigned expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    function automatic logic [FB_W-1:0] modelPack(input logic [7:0] r, input logic [7:0] g,
                                                  input logic [7:0] b);
`ifdef FB_RGB565_EN
        return {r[7:3], g[7:2], b[7:3]};
`else
        return {r, g, b};
`endif
    endfunction

    // The pixel at linear address a of a WxH frame, as the raymarcher paints it.
    function automatic logic [FB_W-1:0] expectedPixel(input int d, input int a);
        int x = a % W;
        int y = a / W;
        if (d == 0 && a == ovAddr) return modelPack(8'hFF, 8'h80, 8'h07);
        return modelPack(x[7:0], y[7:0], 8'h5A);
    endfunction

    // Raymarcher model for one DUT: sample the coordinate the cycle after a
    // pulse; each pulse returns the colour of the sample taken two pulses ago.
    task automatic rmStep(input int d);
        if (justPulsed[d]) begin
            s2x[d] = s1x[d];
            s2y[d] = s1y[d];
            s1x[d] = int'(cxS[d]);
            s1y[d] = int'(cyS[d]);
        end
        justPulsed[d] = 1'b0;
        pdone[d] = 1'b0;
        red[d] = 8'h00;
        green[d] = 8'h00;
        blue[d] = 8'h00;
        if (rmEn[d]) begin
            rmCnt[d]++;
            if (rmCnt[d] >= rmPeriod[d]) begin
                rmCnt[d] = 0;
                pdone[d] = 1'b1;
                justPulsed[d] = 1'b1;
                if (d == 0 && s2x[d] == ovX && s2y[d] == ovY) begin
                    red[d] = 8'hFF;
                    green[d] = 8'h80;
                    blue[d] = 8'h07;
                end else begin
                    red[d] = s2x[d][7:0];
                    green[d] = s2y[d][7:0];
                    blue[d] = 8'h5A;
                end
            end
        end
    endtask

    // One clock of stimulus; inputs change just after the falling edge.
    task automatic applyStimulus();
        @(negedge clk);
        #1;
        rmStep(0);
        rmStep(1);
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus();
    endtask

    task automatic startFrame(input int d, input bit alignWithDone);
        int n = 0;
        if (alignWithDone) begin
            while (pdone[d] !== 1'b1 && n < 20) begin
                applyStimulus();
                n++;
            end
            checkOutput("start_align", pdone[d], 1);
        end
        start[d] = 1'b1;
        applyStimulus();
        start[d] = 1'b0;
    endtask

    task automatic waitFrames(input int d, input int target, input int budget, input string name);
        int n = 0;
        while (frames[d] < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, frames[d] >= target, 1);
    endtask

    task automatic waitWrites(input int d, input int target, input int budget, input string name);
        int n = 0;
        while (writes[d] < target && n < budget) begin
            applyStimulus();
            n++;
        end
        checkOutput(name, writes[d] >= target, 1);
    endtask

    // Pulse bookkeeping at the edge the DUT sees pixel_done.
    always @(posedge clk) begin
        for (int d = 0; d < 2; d++) begin
            sawDone[d] <= pdone[d];
            pulseCount[d] <= pulseCount[d] + (pdone[d] ? 1 : 0);
        end
    end

    task automatic compareDut(input int d);
        if (!rst_n) begin
            expAddr[d] = 0;
            lastData[d] = '0;
            runLen[d] = 0;
        end else if (weS[d]) begin
            checkOutput($sformatf("wr_addr[%0d]", d), addrS[d], expAddr[d]);
            checkOutput($sformatf("wr_data[%0d]", d), dataS[d], expectedPixel(d, expAddr[d]));
            checkOutput($sformatf("wr_frame_done[%0d]", d), fdS[d], (expAddr[d] == NPIX - 1));
            checkOutput($sformatf("wr_follows_done[%0d]", d), sawDone[d], 1);
            captured[d][addrS[d]] = dataS[d];
            lastData[d] = dataS[d];
            writes[d]++;
            runLen[d]++;
            if (runLen[d] > maxRun[d]) maxRun[d] = runLen[d];
            if (fdS[d]) begin
                frames[d]++;
                lastFramePulses[d] = pulseCount[d] - pulseAtFd[d];
                pulseAtFd[d] = pulseCount[d];
            end
            expAddr[d] = (expAddr[d] + 1) % NPIX;
        end else begin
            checkOutput($sformatf("fd_without_write[%0d]", d), fdS[d], 0);
            checkOutput($sformatf("hold_data[%0d]", d), dataS[d], lastData[d]);
            runLen[d] = 0;
        end
    endtask

    // Scoreboard compare on every falling edge.
    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) compareDut(d);
    end

    initial begin
        int wBase, fBase;
        for (int d = 0; d < 2; d++) begin
            start[d] = 1'b0;
            pdone[d] = 1'b0;
            red[d] = 8'h00;
            green[d] = 8'h00;
            blue[d] = 8'h00;
            rmEn[d] = 1'b0;
            rmPeriod[d] = 5;
            rmCnt[d] = 0;
            justPulsed[d] = 1'b0;
            s1x[d] = 0; s1y[d] = 0; s2x[d] = 0; s2y[d] = 0;
            expAddr[d] = 0; lastData[d] = '0;
            writes[d] = 0; frames[d] = 0; runLen[d] = 0; maxRun[d] = 0;
            pulseAtFd[d] = 0; lastFramePulses[d] = 0;
        end
        rst_n = 1'b0;
        idleCycles(3);

        $display("[TB] reset state");
        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("rst_we[%0d]", d), weS[d], 0);
            checkOutput($sformatf("rst_addr[%0d]", d), addrS[d], 0);
            checkOutput($sformatf("rst_data[%0d]", d), dataS[d], 0);
            checkOutput($sformatf("rst_busy[%0d]", d), busyS[d], 0);
            checkOutput($sformatf("rst_fd[%0d]", d), fdS[d], 0);
            checkOutput($sformatf("rst_cx[%0d]", d), cxS[d], 0);
            checkOutput($sformatf("rst_cy[%0d]", d), cyS[d], 0);
        end
        rst_n = 1'b1;

        $display("[TB] single frame, one result every 5 cycles");
        rmEn[0] = 1'b1;
        idleCycles(15);
        checkOutput("idle_busy", busyS[0], 0);
        wBase = writes[0];
        fBase = frames[0];
        startFrame(0, 1'b0);
        checkOutput("sync_busy", busyS[0], 1);
        waitFrames(0, fBase + 1, 200, "t1_frame_timeout");
        checkOutput("t1_writes", writes[0] - wBase, 8);
        checkOutput("t1_busy_after", busyS[0], 0);
        checkOutput("t1_pix5_literal", captured[0][5], LIT_PIX5);
        checkOutput("t1_pix7_literal", captured[0][7], LIT_PIX7);
        idleCycles(15);
        checkOutput("t1_no_idle_writes", writes[0] - wBase, 8);
        checkOutput("t1_frame_once", frames[0] - fBase, 1);
        checkOutput("t1_idle_curr_x", cxS[0], 0);

        $display("[TB] continuous mode, two frames back to back");
        rmEn[1] = 1'b1;
        idleCycles(15);
        wBase = writes[1];
        startFrame(1, 1'b0);
        waitFrames(1, 2, 400, "t2_frame_timeout");
        checkOutput("t2_writes", writes[1] - wBase, 16);
        checkOutput("t2_pulses_second_frame", lastFramePulses[1], 8);
        checkOutput("t2_still_busy", busyS[1], 1);
        rmEn[1] = 1'b0;

        $display("[TB] reset in the middle of a frame");
        idleCycles(15);
        wBase = writes[0];
        fBase = frames[0];
        startFrame(0, 1'b0);
        waitWrites(0, wBase + 4, 200, "t4_write_timeout");
        checkOutput("t4_addr_before_reset", addrS[0], 3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("t4_async_we", weS[0], 0);
        checkOutput("t4_async_addr", addrS[0], 0);
        checkOutput("t4_async_data", dataS[0], 0);
        checkOutput("t4_async_busy", busyS[0], 0);
        checkOutput("t4_async_fd", fdS[0], 0);
        checkOutput("t4_async_cx", cxS[0], 0);
        checkOutput("t4_async_busy1", busyS[1], 0);
        idleCycles(3);
        rst_n = 1'b1;
        idleCycles(15);
        checkOutput("t4_no_frame_done", frames[0] - fBase, 0);
        wBase = writes[0];
        startFrame(0, 1'b0);
        waitFrames(0, fBase + 1, 200, "t4_restart_timeout");
        checkOutput("t4_restart_writes", writes[0] - wBase, 8);

        $display("[TB] start during RUN, override colour at (2,0)");
        ovX = 2; ovY = 0; ovAddr = 2;
        idleCycles(15);
        wBase = writes[0];
        fBase = frames[0];
        startFrame(0, 1'b0);
        waitWrites(0, wBase + 3, 200, "t5_write_timeout");
        start[0] = 1'b1;
        applyStimulus();
        start[0] = 1'b0;
        waitFrames(0, fBase + 1, 200, "t5_frame_timeout");
        checkOutput("t5_writes", writes[0] - wBase, 8);
        checkOutput("t6_packed_literal", captured[0][2], LIT_OVR);
        checkOutput("t5_busy_after", busyS[0], 0);
        idleCycles(2);
        ovX = -1; ovY = -1; ovAddr = -1;

        $display("[TB] back-to-back results, start coincident with pixel_done");
        rmPeriod[0] = 1;
        idleCycles(15);
        wBase = writes[0];
        fBase = frames[0];
        maxRun[0] = 0;
        startFrame(0, 1'b1);
        waitFrames(0, fBase + 1, 100, "t3_frame_timeout");
        checkOutput("t3_writes", writes[0] - wBase, 8);
        checkOutput("t3_consecutive_we", maxRun[0], 8);
        idleCycles(10);
        checkOutput("t3_no_idle_writes", writes[0] - wBase, 8);
        checkOutput("t3_busy_after", busyS[0], 0);
        rmEn[0] = 1'b0;
        idleCycles(3);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
